uart_configurable: RTL and testbench
====================================

Name: uart_configurable

Overview:
Full-duplex UART with run-time configuration and error reporting. It is the parametrised successor of the team's fixed-baud 8N1 UART, and sits between a register interface and the board pins. Baud divisor, parity and stop-bit count are set at run time. RX and TX buffering depth is set by parameter, and parity, framing and overrun errors are reported as sticky flags.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
FIFO_DEPTH_LOG2, 2, log2 of RX and TX FIFO depth (depth 4 by default)
DIV_WIDTH, 16, width of the run-time baud divisor
SAMPLE_RATE, 16, oversampling ticks per bit (fixed 16; parameter documents it)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous reset, active-high
Divisor  in  DIV_WIDTH  tick every Divisor+1 clocks
ParityEn  in  1  1 = parity bit after data
ParityOdd  in  1  1 = odd parity, 0 = even
TwoStop  in  1  1 = two stop bits
WriteUart  in  1  push WriteData into TX FIFO
WriteData  in  DATA_BITS  TX byte
TxFull  out  1  TX FIFO full
TxBusy  out  1  frame in flight or TX FIFO non-empty
ReadUart  in  1  pop RX FIFO head
ReadData  out  DATA_BITS  RX FIFO head (first-word-fall-through)
RxEmpty  out  1  RX FIFO empty
RxFull  out  1  RX FIFO full
Rx  in  1  serial input (asynchronous)
Tx  out  1  serial output, idle high
ParityErr  out  1  sticky parity error
FrameErr  out  1  sticky framing error
Overrun  out  1  sticky overrun
ClearErr  in  1  clears all three sticky flags

Behaviour:
- Reset values (next edge with Reset=1): Tx=1, TxFull=0, TxBusy=0, RxEmpty=1, RxFull=0, ParityErr=0, FrameErr=0, Overrun=0, ReadData=0. Both FIFOs are emptied and both FSMs go to IDLE. Reset mid-frame aborts the frame and Tx returns high the next cycle.
- Tick generator:
  - Counter runs 0..Divisor and pulses Tick for one clock at Divisor, then wraps to 0.
  - Divisor=0 gives a tick every clock.
  - A Divisor change takes effect at the next wrap.
- Configuration (ParityEn, ParityOdd, TwoStop) is latched at frame start, separately for TX and RX. Changes mid-frame are ignored.
- Rx passes through a 2-flop synchroniser, adding 2 clocks of latency.
- FIFOs:
  - Circular buffers with pointers one bit wider than the address.
  - A write when full is ignored, even if a read occurs in the same cycle.
  - A read when empty is ignored.
  - A simultaneous read and write when non-empty and non-full both succeed, and the count is unchanged.
  - ReadData is forced to 0 while RxEmpty=1.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE: if the TX FIFO is non-empty, pop the head into the shift register (one-cycle internal read) and go to START. The pop occurs the cycle after the write lands.
  - START: Tx=0 for 16 ticks.
  - DATA: DATA_BITS bits, LSB first, 16 ticks each.
  - PARITY (only if ParityEn): Tx = XOR of the data bits, XOR ParityOdd, for 16 ticks.
  - STOP: Tx=1 for 16 ticks (32 if TwoStop), then IDLE. Back-to-back frames have no extra idle gap.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE: synchronised Rx=0 goes to START with the tick counter cleared.
  - START: at tick 7, if Rx is still 0 go to DATA, else return to IDLE (glitch rejection).
  - DATA: sample each bit at tick 15 of its 16-tick window, mid-bit, and shift in LSB first.
  - PARITY: the sample is compared to the expected parity.
  - STOP: one stop bit is sampled. If it is 0, FrameErr is set.
  - Frame complete: push the byte into the RX FIFO even with a parity or framing error. If the FIFO is full, drop the byte and set Overrun. Return to IDLE; a second stop bit is not checked.
- Error flags: set on the detecting cycle and held until a ClearErr pulse. If set and clear occur in the same cycle, set wins.

Test Plan:
- Reset, Divisor=0, 8N1, loopback Tx→Rx, write 8'hA5 → Tx low 16 clocks, then 1,0,1,0,0,1,0,1 for 16 clocks each, then high 16 (160-clock frame); RxEmpty falls, ReadData=8'hA5, no errors.
- ParityEn=1, ParityOdd=0, TwoStop=1, write 8'h07 → parity bit 1, stop high 32 clocks, 192-clock frame, ParityErr=0. Bench flips the parity bit on Rx → ParityErr=1 and 8'h07 is still stored.
- Divisor=3, WriteUart held for 6 consecutive cycles with 8'h01..8'h06 → TxFull=1 after the 6th write, 8'h06 is dropped, bytes 01..05 are serialised with 64 clocks per bit, TxBusy falls after the last stop bit.
- Loopback sends 5 bytes 8'h11..8'h15 without reads → RxFull=1 after the 4th byte, Overrun=1 after the 5th; reads return 11,12,13,14, then RxEmpty=1.
- Drive Rx frame 8'h3C with a low stop bit → FrameErr=1; ClearErr pulse → 0. Rx low for 4 clocks at Divisor=0 → no byte, no error.
- Assert Reset at clock 80 of a 160-clock frame → next cycle Tx=1, TxBusy=0, FIFOs empty; new write 8'h5A transmits cleanly.

Source files
------------

// File: rtl/uart_configurable.sv
// Full-duplex UART with run-time divisor, parity and stop-bit selection,
// FIFO buffering in both directions and sticky parity/framing/overrun flags.
module uart_configurable #(
   parameter int DATA_BITS       = 8,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int DIV_WIDTH       = 16,
   parameter int SAMPLE_RATE     = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [DIV_WIDTH-1:0] Divisor,
   input  logic                 ParityEn,
   input  logic                 ParityOdd,
   input  logic                 TwoStop,
   input  logic                 WriteUart,
   input  logic [DATA_BITS-1:0] WriteData,
   output logic                 TxFull,
   output logic                 TxBusy,
   input  logic                 ReadUart,
   output logic [DATA_BITS-1:0] ReadData,
   output logic                 RxEmpty,
   output logic                 RxFull,
   input  logic                 Rx,
   output logic                 Tx,
   output logic                 ParityErr,
   output logic                 FrameErr,
   output logic                 Overrun,
   input  logic                 ClearErr
);
   localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int TW = $clog2(2 * SAMPLE_RATE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int PW = FIFO_DEPTH_LOG2 + 1;
   localparam logic [TW-1:0] LAST_TICK       = TW'(SAMPLE_RATE - 1);
   localparam logic [TW-1:0] MID_TICK        = TW'(SAMPLE_RATE / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK_2STOP = TW'(2 * SAMPLE_RATE - 1);
   localparam logic [BW-1:0] LAST_BIT        = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

   // ---------------- baud tick generator ----------------
   logic [DIV_WIDTH-1:0] tick_cnt_reg;
   logic [DIV_WIDTH-1:0] div_reg;
   logic                 tick;

   assign tick = (tick_cnt_reg == div_reg);

   // The divisor is only re-sampled on a wrap so a change never produces a short period.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         tick_cnt_reg <= '0;
         div_reg      <= Divisor;
      end else if (tick) begin
         tick_cnt_reg <= '0;
         div_reg      <= Divisor;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + DIV_WIDTH'(1);
      end
   end

   // ---------------- Rx synchroniser ----------------
   logic rx_meta_reg;
   logic rx_sync_reg;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
      end else begin
         rx_meta_reg <= Rx;
         rx_sync_reg <= rx_meta_reg;
      end
   end

   // ---------------- FIFOs: index 0 = TX, index 1 = RX ----------------
   logic                 fifo_wr    [2];
   logic                 fifo_rd    [2];
   logic [DATA_BITS-1:0] fifo_wdata [2];
   logic [DATA_BITS-1:0] fifo_rdata [2];
   logic                 fifo_empty [2];
   logic                 fifo_full  [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
      logic [PW-1:0]        wr_ptr_reg;
      logic [PW-1:0]        rd_ptr_reg;
      logic                 wr_ok;
      logic                 rd_ok;

      assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign fifo_full[gi]  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                              (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
      // Full blocks the write even when a read frees a slot in the same cycle.
      assign wr_ok = fifo_wr[gi] && !fifo_full[gi];
      assign rd_ok = fifo_rd[gi] && !fifo_empty[gi];
      assign fifo_rdata[gi] = fifo_empty[gi] ? '0 : mem[rd_ptr_reg[PW-2:0]];

      always_ff @(posedge Clock) begin
         if (wr_ok) begin
            mem[wr_ptr_reg[PW-2:0]] <= fifo_wdata[gi];
         end
      end

      always_ff @(posedge Clock) begin
         if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (wr_ok) begin
               wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (rd_ok) begin
               rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
         end
      end
   end

   // ---------------- transmitter ----------------
   uart_state_t          tx_state_reg, tx_state_next;
   logic [TW-1:0]        tx_tick_reg, tx_tick_next;
   logic [BW-1:0]        tx_bit_reg, tx_bit_next;
   logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
   logic                 tx_par_en_reg, tx_par_en_next;
   logic                 tx_two_stop_reg, tx_two_stop_next;
   logic                 tx_par_bit_reg, tx_par_bit_next;
   logic                 tx_reg, tx_next;
   logic                 tx_start_frame;

   always_comb begin
      tx_state_next    = tx_state_reg;
      tx_tick_next     = tx_tick_reg;
      tx_bit_next      = tx_bit_reg;
      tx_shift_next    = tx_shift_reg;
      tx_par_en_next   = tx_par_en_reg;
      tx_two_stop_next = tx_two_stop_reg;
      tx_par_bit_next  = tx_par_bit_reg;
      tx_start_frame   = 1'b0;
      tx_next          = 1'b1;

      case (tx_state_reg)
         S_IDLE: begin
            tx_start_frame = !fifo_empty[0];
         end
         S_START: begin
            if (tick) begin
               if (tx_tick_reg == LAST_TICK) begin
                  tx_tick_next  = '0;
                  tx_state_next = S_DATA;
               end else begin
                  tx_tick_next = tx_tick_reg + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tx_tick_reg == LAST_TICK) begin
                  tx_tick_next  = '0;
                  tx_shift_next = tx_shift_reg >> 1;
                  if (tx_bit_reg == LAST_BIT) begin
                     tx_bit_next   = '0;
                     tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
                  end else begin
                     tx_bit_next = tx_bit_reg + BW'(1);
                  end
               end else begin
                  tx_tick_next = tx_tick_reg + TW'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               if (tx_tick_reg == LAST_TICK) begin
                  tx_tick_next  = '0;
                  tx_state_next = S_STOP;
               end else begin
                  tx_tick_next = tx_tick_reg + TW'(1);
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tx_tick_reg == (tx_two_stop_reg ? LAST_TICK_2STOP : LAST_TICK)) begin
                  tx_tick_next   = '0;
                  tx_state_next  = S_IDLE;
                  tx_start_frame = !fifo_empty[0];
               end else begin
                  tx_tick_next = tx_tick_reg + TW'(1);
               end
            end
         end
         default: tx_state_next = S_IDLE;
      endcase

      // Chaining straight from the last stop tick keeps back-to-back frames gapless.
      if (tx_start_frame) begin
         tx_state_next    = S_START;
         tx_tick_next     = '0;
         tx_bit_next      = '0;
         tx_shift_next    = fifo_rdata[0];
         tx_par_en_next   = ParityEn;
         tx_two_stop_next = TwoStop;
         tx_par_bit_next  = (^fifo_rdata[0]) ^ ParityOdd;
      end

      case (tx_state_next)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = tx_shift_next[0];
         S_PARITY: tx_next = tx_par_bit_next;
         default:  tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         tx_state_reg    <= S_IDLE;
         tx_tick_reg     <= '0;
         tx_bit_reg      <= '0;
         tx_shift_reg    <= '0;
         tx_par_en_reg   <= 1'b0;
         tx_two_stop_reg <= 1'b0;
         tx_par_bit_reg  <= 1'b0;
         tx_reg          <= 1'b1;
      end else begin
         tx_state_reg    <= tx_state_next;
         tx_tick_reg     <= tx_tick_next;
         tx_bit_reg      <= tx_bit_next;
         tx_shift_reg    <= tx_shift_next;
         tx_par_en_reg   <= tx_par_en_next;
         tx_two_stop_reg <= tx_two_stop_next;
         tx_par_bit_reg  <= tx_par_bit_next;
         tx_reg          <= tx_next;
      end
   end

   assign fifo_wr[0]    = WriteUart;
   assign fifo_wdata[0] = WriteData;
   assign fifo_rd[0]    = tx_start_frame;

   // ---------------- receiver ----------------
   uart_state_t          rx_state_reg, rx_state_next;
   logic [TW-1:0]        rx_tick_reg, rx_tick_next;
   logic [BW-1:0]        rx_bit_reg, rx_bit_next;
   logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
   logic                 rx_par_en_reg, rx_par_en_next;
   logic                 rx_par_odd_reg, rx_par_odd_next;
   logic                 rx_push;
   logic                 parity_set;
   logic                 frame_set;
   logic                 overrun_set;

   always_comb begin
      rx_state_next   = rx_state_reg;
      rx_tick_next    = rx_tick_reg;
      rx_bit_next     = rx_bit_reg;
      rx_shift_next   = rx_shift_reg;
      rx_par_en_next  = rx_par_en_reg;
      rx_par_odd_next = rx_par_odd_reg;
      rx_push         = 1'b0;
      parity_set      = 1'b0;
      frame_set       = 1'b0;

      case (rx_state_reg)
         S_IDLE: begin
            if (!rx_sync_reg) begin
               rx_state_next   = S_START;
               rx_tick_next    = '0;
               rx_bit_next     = '0;
               rx_par_en_next  = ParityEn;
               rx_par_odd_next = ParityOdd;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_tick_reg == MID_TICK) begin
                  rx_tick_next  = '0;
                  rx_state_next = rx_sync_reg ? S_IDLE : S_DATA;
               end else begin
                  rx_tick_next = rx_tick_reg + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (rx_tick_reg == LAST_TICK) begin
                  rx_tick_next  = '0;
                  rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                  if (rx_bit_reg == LAST_BIT) begin
                     rx_bit_next   = '0;
                     rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
                  end else begin
                     rx_bit_next = rx_bit_reg + BW'(1);
                  end
               end else begin
                  rx_tick_next = rx_tick_reg + TW'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               if (rx_tick_reg == LAST_TICK) begin
                  rx_tick_next  = '0;
                  parity_set    = rx_sync_reg != ((^rx_shift_reg) ^ rx_par_odd_reg);
                  rx_state_next = S_STOP;
               end else begin
                  rx_tick_next = rx_tick_reg + TW'(1);
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (rx_tick_reg == LAST_TICK) begin
                  rx_tick_next  = '0;
                  frame_set     = !rx_sync_reg;
                  rx_push       = 1'b1;
                  rx_state_next = S_IDLE;
               end else begin
                  rx_tick_next = rx_tick_reg + TW'(1);
               end
            end
         end
         default: rx_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rx_state_reg   <= S_IDLE;
         rx_tick_reg    <= '0;
         rx_bit_reg     <= '0;
         rx_shift_reg   <= '0;
         rx_par_en_reg  <= 1'b0;
         rx_par_odd_reg <= 1'b0;
      end else begin
         rx_state_reg   <= rx_state_next;
         rx_tick_reg    <= rx_tick_next;
         rx_bit_reg     <= rx_bit_next;
         rx_shift_reg   <= rx_shift_next;
         rx_par_en_reg  <= rx_par_en_next;
         rx_par_odd_reg <= rx_par_odd_next;
      end
   end

   assign fifo_wr[1]    = rx_push;
   assign fifo_wdata[1] = rx_shift_reg;
   assign fifo_rd[1]    = ReadUart;
   assign overrun_set   = rx_push && fifo_full[1];

   // ---------------- sticky error flags (set beats clear) ----------------
   logic parity_err_reg;
   logic frame_err_reg;
   logic overrun_reg;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         parity_err_reg <= parity_set  | (parity_err_reg & ~ClearErr);
         frame_err_reg  <= frame_set   | (frame_err_reg  & ~ClearErr);
         overrun_reg    <= overrun_set | (overrun_reg    & ~ClearErr);
      end
   end

   assign Tx        = tx_reg;
   assign TxFull    = fifo_full[0];
   assign TxBusy    = (tx_state_reg != S_IDLE) || !fifo_empty[0];
   assign ReadData  = fifo_rdata[1];
   assign RxEmpty   = fifo_empty[1];
   assign RxFull    = fifo_full[1];
   assign ParityErr = parity_err_reg;
   assign FrameErr  = frame_err_reg;
   assign Overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_configurable.sv
// Directed bench for uart_configurable: waveform shape, loopback reception,
// FIFO limits, error flags, glitch rejection and mid-frame reset.
module tb_uart_configurable;
   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] Divisor = '0;
   logic        ParityEn = 1'b0;
   logic        ParityOdd = 1'b0;
   logic        TwoStop = 1'b0;
   logic        WriteUart = 1'b0;
   logic [7:0]  WriteData = '0;
   logic        TxFull;
   logic        TxBusy;
   logic        ReadUart = 1'b0;
   logic [7:0]  ReadData;
   logic        RxEmpty;
   logic        RxFull;
   logic        Rx;
   logic        Tx;
   logic        ParityErr;
   logic        FrameErr;
   logic        Overrun;
   logic        ClearErr = 1'b0;

   logic use_loop = 1'b1;
   logic rx_drv = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;

   assign Rx = use_loop ? Tx : rx_drv;

   uart_configurable dut (
      .Clock(Clock), .Reset(Reset), .Divisor(Divisor), .ParityEn(ParityEn),
      .ParityOdd(ParityOdd), .TwoStop(TwoStop), .WriteUart(WriteUart),
      .WriteData(WriteData), .TxFull(TxFull), .TxBusy(TxBusy), .ReadUart(ReadUart),
      .ReadData(ReadData), .RxEmpty(RxEmpty), .RxFull(RxFull), .Rx(Rx), .Tx(Tx),
      .ParityErr(ParityErr), .FrameErr(FrameErr), .Overrun(Overrun), .ClearErr(ClearErr)
   );

   always #5 Clock = ~Clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("  check %-16s got %0h exp %0h", tag, got, exp);
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n clocks and settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      WriteUart = 1'b1;
      WriteData = d;
      step(1);
      WriteUart = 1'b0;
   endtask

   task automatic pulse_read();
      ReadUart = 1'b1;
      step(1);
      ReadUart = 1'b0;
   endtask

   task automatic pulse_clear();
      ClearErr = 1'b1;
      step(1);
      ClearErr = 1'b0;
   endtask

   task automatic wait_tx_fall(input string tag, input int limit);
      int k = 0;
      while (Tx !== 1'b0 && k < limit) begin
         step(1);
         k++;
      end
      check_value(tag, Tx, 1'b0);
   endtask

   // Divisor=0 frame: compare Tx every clock against the expected 16-clock bit cells.
   task automatic check_frame(input string tag, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic two_stop);
      logic [15:0] lv;
      int nb;
      int errs = 0;
      lv = '1;
      lv[0] = 1'b0;
      lv[8:1] = d;
      if (par_en) lv[9] = par_bit;
      nb = 10 + int'(par_en) + int'(two_stop);
      wait_tx_fall({tag, "_start"}, 20);
      for (int i = 0; i < nb * 16; i++) begin
         if (Tx !== lv[i / 16]) errs++;
         step(1);
      end
      check_value({tag, "_wave"}, errs, 0);
      check_value({tag, "_idle"}, Tx, 1'b1);
   endtask

   // Divisor=3: sample Tx near the middle of each 64-clock bit cell.
   task automatic capture_div3(input int pos0, output logic [9:0] lv);
      int pos = pos0;
      for (int b = 0; b < 10; b++) begin
         step(30 + 64 * b - pos);
         pos = 30 + 64 * b;
         lv[b] = Tx;
      end
   endtask

   task automatic send_rx(input logic [7:0] d, input logic par_en, input logic par_bit,
                          input logic stop_bit);
      rx_drv = 1'b0;
      step(16);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         step(16);
      end
      if (par_en) begin
         rx_drv = par_bit;
         step(16);
      end
      rx_drv = stop_bit;
      step(16);
      rx_drv = 1'b1;
      step(16);
   endtask

   initial begin
      logic [9:0] lv;
      int k;

      // Reset state
      step(2);
      check_value("rst_tx", Tx, 1'b1);
      check_value("rst_txfull", TxFull, 1'b0);
      check_value("rst_txbusy", TxBusy, 1'b0);
      check_value("rst_rxempty", RxEmpty, 1'b1);
      check_value("rst_rxfull", RxFull, 1'b0);
      check_value("rst_errs", {ParityErr, FrameErr, Overrun}, 3'b000);
      check_value("rst_rdata", ReadData, 8'h00);
      Reset = 1'b0;
      step(1);

      // 8N1 loopback of A5
      write_byte(8'hA5);
      check_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
      check_value("a5_rxempty", RxEmpty, 1'b0);
      check_value("a5_rdata", ReadData, 8'hA5);
      check_value("a5_errs", {ParityErr, FrameErr, Overrun}, 3'b000);
      pulse_read();
      check_value("a5_pop_empty", RxEmpty, 1'b1);
      check_value("a5_pop_rdata", ReadData, 8'h00);

      // Even parity, two stop bits; then a frame with the parity bit flipped
      ParityEn = 1'b1;
      ParityOdd = 1'b0;
      TwoStop = 1'b1;
      write_byte(8'h07);
      check_frame("p07", 8'h07, 1'b1, 1'b1, 1'b1);
      check_value("p07_perr", ParityErr, 1'b0);
      check_value("p07_rdata", ReadData, 8'h07);
      pulse_read();
      use_loop = 1'b0;
      send_rx(8'h07, 1'b1, 1'b0, 1'b1);
      check_value("pbad_perr", ParityErr, 1'b1);
      check_value("pbad_ferr", FrameErr, 1'b0);
      check_value("pbad_rdata", ReadData, 8'h07);
      pulse_clear();
      check_value("pbad_clear", ParityErr, 1'b0);
      pulse_read();

      // Divisor=3, six back-to-back writes into a depth-4 FIFO
      ParityEn = 1'b0;
      TwoStop = 1'b0;
      Divisor = 16'd3;
      step(2);
      for (int i = 1; i <= 6; i++) begin
         WriteUart = 1'b1;
         WriteData = 8'(i);
         step(1);
      end
      WriteUart = 1'b0;
      check_value("d3_txfull", TxFull, 1'b1);
      for (int f = 1; f <= 5; f++) begin
         if (f > 1) wait_tx_fall("d3_fall", 100);
         capture_div3((f == 1) ? 4 : 0, lv);
         check_value($sformatf("d3_byte%0d", f), lv[8:1], 8'(f));
         check_value($sformatf("d3_frame%0d", f), {lv[9], lv[0]}, 2'b10);
      end
      check_value("d3_busy_stop", TxBusy, 1'b1);
      k = 0;
      while (TxBusy !== 1'b0 && k < 100) begin
         step(1);
         k++;
      end
      check_value("d3_busy_fall", TxBusy, 1'b0);
      step(100);
      check_value("d3_no_byte6", {Tx, TxFull, TxBusy}, 3'b100);

      // Five loopback bytes with no reads: RX FIFO fills, fifth byte overruns
      Divisor = 16'd0;
      step(8);
      use_loop = 1'b1;
      for (int i = 0; i < 5; i++) begin
         WriteUart = 1'b1;
         WriteData = 8'h11 + 8'(i);
         step(1);
      end
      WriteUart = 1'b0;
      step(677);
      check_value("ov_rxfull4", RxFull, 1'b1);
      check_value("ov_before", Overrun, 1'b0);
      k = 0;
      while (TxBusy !== 1'b0 && k < 300) begin
         step(1);
         k++;
      end
      check_value("ov_txdone", TxBusy, 1'b0);
      step(4);
      check_value("ov_after", Overrun, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check_value($sformatf("ov_read%0d", i), ReadData, 8'h11 + 8'(i));
         pulse_read();
      end
      check_value("ov_empty", {RxEmpty, RxFull}, 2'b10);
      check_value("ov_rdata0", ReadData, 8'h00);
      pulse_clear();
      check_value("ov_clear", Overrun, 1'b0);

      // Framing error, then a short glitch
      use_loop = 1'b0;
      send_rx(8'h3C, 1'b0, 1'b0, 1'b0);
      check_value("fe_ferr", FrameErr, 1'b1);
      check_value("fe_perr", ParityErr, 1'b0);
      check_value("fe_rdata", ReadData, 8'h3C);
      pulse_clear();
      check_value("fe_clear", FrameErr, 1'b0);
      pulse_read();
      rx_drv = 1'b0;
      step(4);
      rx_drv = 1'b1;
      step(40);
      check_value("gl_empty", RxEmpty, 1'b1);
      check_value("gl_errs", {ParityErr, FrameErr, Overrun}, 3'b000);

      // Reset in the middle of the second of three queued frames
      use_loop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         WriteUart = 1'b1;
         WriteData = (i == 0) ? 8'hA5 : ((i == 1) ? 8'hC3 : 8'h99);
         step(1);
      end
      WriteUart = 1'b0;
      step(239);
      check_value("mr_pre_rx", RxEmpty, 1'b0);
      check_value("mr_pre_tx", Tx, 1'b0);
      Reset = 1'b1;
      step(1);
      check_value("mr_tx", Tx, 1'b1);
      check_value("mr_busy", TxBusy, 1'b0);
      check_value("mr_fifos", {RxEmpty, RxFull, TxFull}, 3'b100);
      Reset = 1'b0;
      step(2);
      write_byte(8'h5A);
      check_frame("5a", 8'h5A, 1'b0, 1'b0, 1'b0);
      check_value("5a_rdata", ReadData, 8'h5A);
      check_value("5a_errs", {ParityErr, FrameErr, Overrun}, 3'b000);
      pulse_read();
      check_value("5a_only", RxEmpty, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
